pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Supervises the board PLL from the free-running 100 MHz input clock. It drives the PLL reset, waits for lock, and debounces lock. It releases a single active-high downstream reset only after lock has been stable. It sits between the clock wizard (its `pll_reset` feeds the PLL `RST`; PLL `LOCKED` feeds `pll_locked`) and the reset inputs of the DDR3 controller and fabric logic. It recovers automatically from lock timeouts and lock loss.

## Interface
- `RST_PULSE_CYCLES`, 16: cycles `pll_reset` is held high per PLL reset attempt (≥2).
- `LOCK_TIMEOUT_CYCLES`, 10000: cycles to wait for lock before re-resetting the PLL; 100 µs at 100 MHz (≥2).
- `LOCK_STABLE_CYCLES`, 256: cycles synchronized lock must stay high before release (≥2).
- `clk_in1`  in  1  free-running board clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `pll_locked`  in  1  PLL LOCKED; asynchronous to `clk_in1`.
- `pll_reset`  out  1  to PLL RST; active-high.
- `sys_reset`  out  1  downstream reset; active-high, synchronous to `clk_in1`.
- `ready`  out  1  high while in RUN; equals `~sys_reset`.
- `lock_lost`  out  1  one-cycle pulse when lock drops in RUN.
- `retry_count`  out  8  lock timeouts since `reset`; saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer, producing `locked_s`. All decisions use `locked_s`.
- One cycle counter, width `$clog2` of the largest parameter. It is cleared on every state entry.
- States:
  - PLL_RST:
    - `pll_reset`=1, `sys_reset`=1.
    - After `RST_PULSE_CYCLES` cycles → WAIT_LOCK.
  - WAIT_LOCK:
    - `pll_reset`=0, `sys_reset`=1.
    - `locked_s`=1 → STABLE.
    - Else, counter reaches `LOCK_TIMEOUT_CYCLES`-1 → PLL_RST and `retry_count`++ (saturating).
  - STABLE:
    - `sys_reset`=1.
    - `locked_s`=0 → WAIT_LOCK with a fresh timeout; no retry increment.
    - Counter reaches `LOCK_STABLE_CYCLES`-1 with lock still high → RUN.
  - RUN:
    - `sys_reset`=0, `ready`=1.
    - `locked_s`=0 → PLL_RST with `lock_lost`=1 for exactly one cycle.
- Simultaneous events:
  - In WAIT_LOCK, lock and timeout in the same cycle: lock wins (→ STABLE, no increment).
  - `reset` overrides everything.
- Reset values:
  - state=PLL_RST, counter=0.
  - `pll_reset`=1, `sys_reset`=1, `ready`=0, `lock_lost`=0, `retry_count`=0.
- Reset mid-operation, in any state: on the next edge all outputs return to their reset values. The PLL reset pulse restarts in full.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- After `reset` deasserts, `pll_reset` stays high for exactly `RST_PULSE_CYCLES` further cycles.
- Synchronizer latency is 2 cycles.
- `sys_reset` falls and `ready` rises exactly `LOCK_STABLE_CYCLES`+3 cycles after the first edge that samples `pll_locked`=1, provided lock stays high throughout.
- When `pll_locked` falls in RUN:
  - `sys_reset` rises and `lock_lost` pulses 3 edges after the first low sample.
  - `pll_reset` rises on the same edge.
- Timeout path: in WAIT_LOCK without lock, `pll_reset` re-asserts `LOCK_TIMEOUT_CYCLES` cycles after entering WAIT_LOCK. `retry_count` updates on that same edge.
- `sys_reset` never glitches low outside RUN.

## Structure
- Shared package `pll_seq_pkg`:
  - state enum `{PLL_RST, WAIT_LOCK, STABLE, RUN}`;
  - default parameter constants;
  - `RETRY_W`=8.
- Sub-module `sync_2ff`: a 2-flop synchronizer with a reset value of 0, reusable by other CDC inputs.
- Top-level module: FSM, counter and output registers.

## Test plan
Bench parameters for all scenarios: `RST_PULSE_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=20, `LOCK_STABLE_CYCLES`=8.
- Normal lock: assert `reset` for 3 cycles, raise `pll_locked` 10 cycles after release and hold it.
  - `pll_reset` is high for 4 cycles after release.
  - `sys_reset` falls and `ready` rises 11 cycles after the first high sample.
  - `retry_count`=0.
- Timeout retry: hold `pll_locked`=0 for 60 cycles after `reset` release.
  - `pll_reset` pulses 4 cycles high every 24 cycles.
  - `retry_count` reaches 2.
  - `sys_reset` stays high.
- Lock glitch in STABLE: lock high, then drop it for 1 cycle 5 cycles into STABLE.
  - FSM returns to WAIT_LOCK with no retry increment.
  - The release occurs 11 cycles after lock returns.
- Lock loss in RUN: drop `pll_locked` while `ready`=1.
  - `lock_lost` is a single-cycle pulse.
  - `sys_reset` and `pll_reset` rise 3 edges after the drop.
  - Full reacquire succeeds.
- Saturation and reset mid-operation:
  - Force 300 timeouts: `retry_count` stays at 255.
  - Assert `reset` in RUN: next edge gives `pll_reset`=1, `sys_reset`=1, `retry_count`=0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and defaults for the PLL reset sequencer
package pll_seq_pkg;

  // Sequencer phases, in the order a healthy bring-up walks through them
  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 10000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 256;

  localparam int RETRY_W = 8;

  // Largest of three cycle limits; sizes the shared phase counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - drives PLL reset, qualifies lock, releases downstream reset
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES
) (
  input  logic               clk_in1,
  input  logic               reset,
  input  logic               pll_locked,
  output logic               pll_reset,
  output logic               sys_reset,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX);

  // Counter values on the last cycle of each timed phase
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic             w_locked_s;
  seq_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_evt_timeout;
  logic             r_evt_lost;

  sync_2ff u_lock_sync (
    .i_clk   (clk_in1),
    .i_reset (reset),
    .i_d     (pll_locked),
    .o_q     (w_locked_s)
  );

  // Phase sequencing: one counter reused by every phase, cleared on each entry
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      r_state       <= PLL_RST;
      r_cnt         <= '0;
      r_evt_timeout <= 1'b0;
      r_evt_lost    <= 1'b0;
    end else begin
      r_evt_timeout <= 1'b0;
      r_evt_lost    <= 1'b0;
      case (r_state)
        PLL_RST: begin
          if (r_cnt == RST_LAST) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock is checked first so a lock arriving on the timeout cycle still counts
          if (w_locked_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_state       <= PLL_RST;
            r_cnt         <= '0;
            r_evt_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!w_locked_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          // Counter idles at zero here so it never wraps during long runs
          if (!w_locked_s) begin
            r_state    <= PLL_RST;
            r_cnt      <= '0;
            r_evt_lost <= 1'b1;
          end
        end
        default: begin
          r_state <= PLL_RST;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Output stage: decodes the settled phase so every output is a clean flop
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      pll_reset   <= 1'b1;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      pll_reset <= (r_state == PLL_RST);
      sys_reset <= (r_state != RUN);
      ready     <= (r_state == RUN);
      lock_lost <= r_evt_lost;
      if (r_evt_timeout && (retry_count != {RETRY_W{1'b1}})) begin
        retry_count <= retry_count + RETRY_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  localparam int RP = 4;
  localparam int TO = 20;
  localparam int LS = 8;

  logic       clk_in1 = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_reset;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in1 = ~clk_in1;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_TIMEOUT_CYCLES (TO),
    .LOCK_STABLE_CYCLES  (LS)
  ) dut (
    .clk_in1     (clk_in1),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .pll_reset   (pll_reset),
    .sys_reset   (sys_reset),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .retry_count (retry_count)
  );

  // Reference model: phase plus the edge number at which it was entered
  localparam int M_RST  = 0;
  localparam int M_WAIT = 1;
  localparam int M_STAB = 2;
  localparam int M_RUN  = 3;

  int m_phase = M_RST;
  int m_t     = 0;
  int m_enter = 0;
  bit m_s1, m_s2;
  bit m_pend_to, m_pend_lost;
  bit e_pll = 1'b1, e_sys = 1'b1, e_rdy = 1'b0, e_lost = 1'b0;
  int e_retry = 0;

  task automatic model_edge(input bit rst, input bit lk);
    bit ls;
    int el;
    m_t++;
    if (rst) begin
      m_phase = M_RST; m_enter = m_t;
      m_s1 = 1'b0; m_s2 = 1'b0;
      m_pend_to = 1'b0; m_pend_lost = 1'b0;
      e_pll = 1'b1; e_sys = 1'b1; e_rdy = 1'b0; e_lost = 1'b0; e_retry = 0;
      return;
    end
    ls = m_s2; m_s2 = m_s1; m_s1 = lk;
    e_pll  = (m_phase == M_RST);
    e_sys  = (m_phase != M_RUN);
    e_rdy  = (m_phase == M_RUN);
    e_lost = m_pend_lost;
    if (m_pend_to && e_retry < 255) e_retry++;
    m_pend_to = 1'b0; m_pend_lost = 1'b0;
    el = m_t - m_enter;
    case (m_phase)
      M_RST:  if (el == RP) begin m_phase = M_WAIT; m_enter = m_t; end
      M_WAIT: if (ls) begin m_phase = M_STAB; m_enter = m_t; end
              else if (el == TO) begin m_phase = M_RST; m_enter = m_t; m_pend_to = 1'b1; end
      M_STAB: if (!ls) begin m_phase = M_WAIT; m_enter = m_t; end
              else if (el == LS) begin m_phase = M_RUN; m_enter = m_t; end
      default: if (!ls) begin m_phase = M_RST; m_enter = m_t; m_pend_lost = 1'b1; end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({pll_reset, sys_reset, ready, lock_lost, retry_count});
  endfunction

  // One clock edge: inputs already driven, model advanced, DUT sampled 1 ns later
  task automatic tick();
    @(posedge clk_in1);
    model_edge(reset, pll_locked);
    #1;
    chk("model", dut_vec(), 32'({e_pll, e_sys, e_rdy, e_lost, 8'(e_retry)}));
  endtask

  typedef struct {
    int rep;
    bit rst;
    bit lk;
    bit pll;
    bit sys;
    bit rdy;
    bit lost;
    int retry;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Normal lock, lock loss in RUN with reacquire, reset in RUN
    tbl.push_back('{3,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{4,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{6,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0});
    tbl.push_back('{3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{1,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{4,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0});

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        reset = tbl[i].rst;
        pll_locked = tbl[i].lk;
        tick();
        chk($sformatf("vec%0d.%0d", i, r), dut_vec(),
            32'({tbl[i].pll, tbl[i].sys, tbl[i].rdy, tbl[i].lost, 8'(tbl[i].retry)}));
      end
    end

    // Timeout retry: no lock for 60 cycles
    reset = 1'b1; pll_locked = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      tick();
      chk("to_sys_high", 32'(sys_reset), 32'd1);
      if (e == 24) begin chk("to_pll_e24", 32'(pll_reset), 32'd0); chk("to_retry_e24", 32'(retry_count), 32'd0); end
      if (e == 25) begin chk("to_pll_e25", 32'(pll_reset), 32'd1); chk("to_retry_e25", 32'(retry_count), 32'd1); end
      if (e == 28) chk("to_pll_e28", 32'(pll_reset), 32'd1);
      if (e == 29) chk("to_pll_e29", 32'(pll_reset), 32'd0);
      if (e == 48) chk("to_retry_e48", 32'(retry_count), 32'd1);
      if (e == 49) begin chk("to_pll_e49", 32'(pll_reset), 32'd1); chk("to_retry_e49", 32'(retry_count), 32'd2); end
      if (e == 60) chk("to_retry_e60", 32'(retry_count), 32'd2);
    end

    // One-cycle lock glitch 5 cycles into STABLE delays release to 11 after return
    reset = 1'b1; pll_locked = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      pll_locked = (e >= 11) && (e != 18);
      tick();
      if (e == 22) chk("gl_not_ready_e22", 32'(ready), 32'd0);
      if (e == 29) chk("gl_not_ready_e29", 32'(ready), 32'd0);
      if (e == 30) begin
        chk("gl_ready_e30", 32'(ready), 32'd1);
        chk("gl_sys_e30", 32'(sys_reset), 32'd0);
        chk("gl_retry_e30", 32'(retry_count), 32'd0);
      end
    end

    // Randomized lock behaviour with occasional resets, checked by the model
    reset = 1'b1; pll_locked = 1'b0;
    tick();
    for (int cyc = 0; cyc < 4000; ) begin
      int len;
      bit rst;
      rst = ($urandom_range(0, 30) == 0);
      pll_locked = 1'($urandom_range(0, 1));
      len = rst ? int'($urandom_range(1, 3)) : int'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 80 : 40));
      reset = rst;
      for (int k = 0; k < len; k++) tick();
      cyc += len;
    end

    // Saturation after 300 timeouts, then reset while in RUN
    reset = 1'b1; pll_locked = 1'b0;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 300 * 24 + 8; e++) begin
      tick();
      if (e == 6120) chk("sat_retry_254", 32'(retry_count), 32'd254);
      if (e == 6121) chk("sat_retry_255", 32'(retry_count), 32'd255);
    end
    chk("sat_retry_end", 32'(retry_count), 32'd255);
    pll_locked = 1'b1;
    for (int e = 0; e < 14; e++) tick();
    chk("sat_ready", 32'(ready), 32'd1);
    chk("sat_retry_run", 32'(retry_count), 32'd255);
    reset = 1'b1;
    tick();
    chk("rst_pll", 32'(pll_reset), 32'd1);
    chk("rst_sys", 32'(sys_reset), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_retry", 32'(retry_count), 32'd0);
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
